button_conditioner: RTL

- Conditions raw, bouncy push-button inputs (paddle up/down, serve, score/menu buttons) into clean levels and single-cycle pulses.
- Sits directly upstream of the mod-n binary counters. Each btn_press bit drives a counter's en input, so one physical press advances the count by exactly 1.
- The channels are independent. Each channel has a 2-flop synchronizer, a debounce counter, a 4-state FSM and pulse generation.

---
 rtl/button_conditioner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, level and one-cycle press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner #(
   parameter int NB           = 4,
   parameter int DB_CYCLES    = 1000000,
   parameter int CW           = 20,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NB-1:0] btn_raw,
   output logic [NB-1:0] btn_level,
   output logic [NB-1:0] btn_press,
   output logic [NB-1:0] btn_release
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [NB-1:0] s1_q, s1_d;
   logic [NB-1:0] s_q, s_d;
   state_t        state_q [NB];
   state_t        state_d [NB];
   logic [CW-1:0] cnt_q   [NB];
   logic [CW-1:0] cnt_d   [NB];
   logic [NB-1:0] level_q, level_d;
   logic [NB-1:0] press_q, press_d;
   logic [NB-1:0] release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int            RW         = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0] RCNT_LAST  = RW'(REPEAT_DELAY - 1);
   // Reloading here makes the next hit land exactly REPEAT_RATE cycles later.
   localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

   logic [RW-1:0] rcnt_q [NB];
   logic [RW-1:0] rcnt_d [NB];
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      s1_d      = btn_raw;
      s_d       = s1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < NB; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
         rcnt_d[i]  = rcnt_q[i];
`endif
         case (state_q[i])
            IDLE: begin
               if (s_q[i]) begin
                  state_d[i] = PRESS_WAIT;
                  cnt_d[i]   = CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!s_q[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = PRESSED;
                  level_d[i] = 1'b1;
                  press_d[i] = 1'b1;
                  cnt_d[i]   = '0;
`ifdef BTN_AUTOREPEAT_EN
                  rcnt_d[i]  = '0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            PRESSED: begin
               if (!s_q[i]) begin
                  state_d[i] = RELEASE_WAIT;
                  cnt_d[i]   = CW'(1);
               end
`ifdef BTN_AUTOREPEAT_EN
               if (rcnt_q[i] == RCNT_LAST) begin
                  press_d[i] = 1'b1;
                  rcnt_d[i]  = RCNT_RELOAD;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + RW'(1);
               end
`endif
            end
            RELEASE_WAIT: begin
               // A short low blip returns to PRESSED without clearing the repeat timer.
               if (s_q[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]   = IDLE;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
                  cnt_d[i]     = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q      <= '0;
         s_q       <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         // NOTE: the per-channel counter arrays are plain flops, so they are reset like any other state.
         for (int i = 0; i < NB; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s_q       <= s_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < NB; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NB; i++) rcnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) rcnt_q[i] <= rcnt_d[i];
      end
   end
`endif

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule
